// File: rtl/btn_conditioner_if.sv
// Button bundle between the raw board pins and the conditioner outputs.
// master = board/stimulus side (drives BTN_IN), slave = btn_conditioner.
interface btn_conditioner_if #(
    parameter int NBTN = 5
);
    logic [NBTN-1:0] BTN_IN;
    logic [NBTN-1:0] BTN_LVL;
    logic [NBTN-1:0] BTN_PRESS;
    logic [NBTN-1:0] BTN_REL;
    logic [NBTN-1:0] BTN_RPT;
    logic [NBTN-1:0] BTN_STEP;

    modport master (
        output BTN_IN,
        input  BTN_LVL,
        input  BTN_PRESS,
        input  BTN_REL,
        input  BTN_RPT,
        input  BTN_STEP
    );

    modport slave (
        input  BTN_IN,
        output BTN_LVL,
        output BTN_PRESS,
        output BTN_REL,
        output BTN_RPT,
        output BTN_STEP
    );
endinterface

// File: rtl/btn_conditioner.sv
// Per-button synchroniser, debouncer, edge detector and auto-repeat step generator.
// Auto-repeat FSMs are built only when BTN_AUTOREPEAT_EN is defined; otherwise BTN_RPT=0.
module btn_conditioner #(
    parameter int              NBTN       = 5,
    parameter int              DEB_CYCLES = 250000,
    parameter int              REP_DELAY  = 6250000,
    parameter int              REP_PERIOD = 2500000,
    parameter logic [NBTN-1:0] REP_MASK   = 5'b01110
) (
    input  logic            CLK25M,
    input  logic            RST_N,
    btn_conditioner_if.slave btn
);

    localparam int               DEB_W    = $clog2(DEB_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int               REP_MAX     = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int               REP_W       = $clog2(REP_MAX);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REP_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REP_PERIOD - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;
`else
    // Repeat configuration has no effect in this build.
    logic unused_rep_cfg;
    assign unused_rep_cfg = ^{REP_MASK, 32'(REP_DELAY), 32'(REP_PERIOD)};
`endif

    logic [NBTN-1:0] lvl_vec;
    logic [NBTN-1:0] press_vec;
    logic [NBTN-1:0] rel_vec;
    logic [NBTN-1:0] rpt_vec;
    logic [NBTN-1:0] step_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_btn
            logic [1:0]       sync_reg;
            logic [DEB_W-1:0] deb_cnt_reg;
            logic [DEB_W-1:0] deb_cnt_next;
            logic             lvl_reg;
            logic             lvl_next;
            logic             press_reg;
            logic             press_next;
            logic             rel_reg;
            logic             rel_next;
            logic             rpt_reg;
            logic             rpt_next;
            logic             step_reg;
            logic             step_next;

            // Level flips only after DEB_CYCLES consecutive mismatching samples.
            always_comb begin
                deb_cnt_next = '0;
                lvl_next     = lvl_reg;
                press_next   = 1'b0;
                rel_next     = 1'b0;
                if (sync_reg[1] != lvl_reg) begin
                    if (deb_cnt_reg == DEB_LAST) begin
                        lvl_next   = ~lvl_reg;
                        press_next = ~lvl_reg;
                        rel_next   = lvl_reg;
                    end else begin
                        deb_cnt_next = deb_cnt_reg + 1'b1;
                    end
                end
            end

`ifdef BTN_AUTOREPEAT_EN
            if (REP_MASK[gi]) begin : g_rpt
                logic [1:0]       state_reg;
                logic [1:0]       state_next;
                logic [REP_W-1:0] rpt_cnt_reg;
                logic [REP_W-1:0] rpt_cnt_next;

                // Release is checked first so it beats a simultaneous count expiry.
                always_comb begin
                    state_next   = state_reg;
                    rpt_cnt_next = rpt_cnt_reg;
                    rpt_next     = 1'b0;
                    if (rel_next) begin
                        state_next   = ST_IDLE;
                        rpt_cnt_next = '0;
                    end else begin
                        case (state_reg)
                            ST_IDLE: begin
                                rpt_cnt_next = '0;
                                if (press_next) begin
                                    state_next = ST_DELAY;
                                end
                            end
                            ST_DELAY: begin
                                if (rpt_cnt_reg == DELAY_LAST) begin
                                    rpt_next     = 1'b1;
                                    rpt_cnt_next = '0;
                                    state_next   = ST_REPEAT;
                                end else begin
                                    rpt_cnt_next = rpt_cnt_reg + 1'b1;
                                end
                            end
                            ST_REPEAT: begin
                                if (rpt_cnt_reg == PERIOD_LAST) begin
                                    rpt_next     = 1'b1;
                                    rpt_cnt_next = '0;
                                end else begin
                                    rpt_cnt_next = rpt_cnt_reg + 1'b1;
                                end
                            end
                            default: begin
                                state_next   = ST_IDLE;
                                rpt_cnt_next = '0;
                            end
                        endcase
                    end
                end

                always_ff @(posedge CLK25M or negedge RST_N) begin
                    if (!RST_N) begin
                        state_reg   <= ST_IDLE;
                        rpt_cnt_reg <= '0;
                    end else begin
                        state_reg   <= state_next;
                        rpt_cnt_reg <= rpt_cnt_next;
                    end
                end
            end else begin : g_norpt
                assign rpt_next = 1'b0;
            end
`else
            assign rpt_next = 1'b0;
`endif

            assign step_next = press_next | rpt_next;

            always_ff @(posedge CLK25M or negedge RST_N) begin
                if (!RST_N) begin
                    sync_reg    <= '0;
                    deb_cnt_reg <= '0;
                    lvl_reg     <= 1'b0;
                    press_reg   <= 1'b0;
                    rel_reg     <= 1'b0;
                    rpt_reg     <= 1'b0;
                    step_reg    <= 1'b0;
                end else begin
                    sync_reg    <= {sync_reg[0], btn.BTN_IN[gi]};
                    deb_cnt_reg <= deb_cnt_next;
                    lvl_reg     <= lvl_next;
                    press_reg   <= press_next;
                    rel_reg     <= rel_next;
                    rpt_reg     <= rpt_next;
                    step_reg    <= step_next;
                end
            end

            assign lvl_vec[gi]   = lvl_reg;
            assign press_vec[gi] = press_reg;
            assign rel_vec[gi]   = rel_reg;
            assign rpt_vec[gi]   = rpt_reg;
            assign step_vec[gi]  = step_reg;
        end
    endgenerate

    assign btn.BTN_LVL   = lvl_vec;
    assign btn.BTN_PRESS = press_vec;
    assign btn.BTN_REL   = rel_vec;
    assign btn.BTN_RPT   = rpt_vec;
    assign btn.BTN_STEP  = step_vec;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: stimulus pushes expected output events,
// a negedge monitor pops and compares whenever any output pulses or the level changes.
module tb_btn_conditioner;

    localparam int              NBTN       = 5;
    localparam int              DEB_CYCLES = 4;
    localparam int              REP_DELAY  = 10;
    localparam int              REP_PERIOD = 3;
    localparam logic [NBTN-1:0] REP_MASK   = 5'b01110;
    localparam int              LAT        = DEB_CYCLES + 2;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    typedef struct {
        int              cyc;
        logic [NBTN-1:0] lvl;
        logic [NBTN-1:0] press;
        logic [NBTN-1:0] rel;
        logic [NBTN-1:0] rpt;
        logic [NBTN-1:0] step;
    } ev_t;

    logic            clk;
    logic            rst_n;
    int              cyc;
    int              n_tests;
    int              n_fail;
    logic [NBTN-1:0] exp_lvl;
    ev_t             exp_q[$];

    btn_conditioner_if #(.NBTN(NBTN)) bif ();

    btn_conditioner #(
        .NBTN      (NBTN),
        .DEB_CYCLES(DEB_CYCLES),
        .REP_DELAY (REP_DELAY),
        .REP_PERIOD(REP_PERIOD),
        .REP_MASK  (REP_MASK)
    ) dut (
        .CLK25M(clk),
        .RST_N (rst_n),
        .btn   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int c, input logic [NBTN-1:0] l, input logic [NBTN-1:0] p,
                                 input logic [NBTN-1:0] r, input logic [NBTN-1:0] rp,
                                 input logic [NBTN-1:0] s);
        ev_t e;
        e.cyc = c; e.lvl = l; e.press = p; e.rel = r; e.rpt = rp; e.step = s;
        exp_q.push_back(e);
    endfunction

    task automatic check_vec(input string name, input logic [NBTN-1:0] got, input logic [NBTN-1:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end else begin
            $display("[TB] %s ok: %b", name, got);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_vec({tag, " BTN_LVL"},   bif.BTN_LVL,   '0);
        check_vec({tag, " BTN_PRESS"}, bif.BTN_PRESS, '0);
        check_vec({tag, " BTN_REL"},   bif.BTN_REL,   '0);
        check_vec({tag, " BTN_RPT"},   bif.BTN_RPT,   '0);
        check_vec({tag, " BTN_STEP"},  bif.BTN_STEP,  '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        int n;
        n = 0;
        while (cyc < c && n < 1000) begin
            tick();
            n++;
        end
    endtask

    // Wait for every pushed event to be consumed, then watch a quiet window for strays.
    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s drain: %0d events pending at cyc %0d, required 0", name, exp_q.size(), cyc);
            exp_q.delete();
        end
        repeat (15) tick();
    endtask

    // Press button b, keep the raw level high until hold cycles after the accepted press.
    task automatic press_hold(input int b, input int hold);
        logic [NBTN-1:0] m;
        int              p;
        int              r;
        int              t;
        m = NBTN'(1) << b;
        tick();
        bif.BTN_IN = bif.BTN_IN | m;
        p = cyc + LAT;
        r = p + hold + LAT;
        exp_lvl = exp_lvl | m;
        push(p, exp_lvl, m, '0, '0, m);
        if (AR && REP_MASK[b]) begin
            t = p + REP_DELAY;
            while (t < r) begin
                push(t, exp_lvl, '0, '0, m, m);
                t += REP_PERIOD;
            end
        end
        wait_until(p + hold);
        bif.BTN_IN = bif.BTN_IN & ~m;
        exp_lvl = exp_lvl & ~m;
        push(r, exp_lvl, '0, m, '0, '0);
    endtask

    // Monitor: any pulse or level change is one DUT transaction.
    initial begin
        logic [NBTN-1:0] prev_lvl;
        ev_t             e;
        prev_lvl = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_lvl = '0;
            end else if (|{bif.BTN_PRESS, bif.BTN_REL, bif.BTN_RPT, bif.BTN_STEP} || bif.BTN_LVL != prev_lvl) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected event: cyc=%0d lvl=%b press=%b rel=%b rpt=%b step=%b, required no event",
                             cyc, bif.BTN_LVL, bif.BTN_PRESS, bif.BTN_REL, bif.BTN_RPT, bif.BTN_STEP);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.lvl !== bif.BTN_LVL || e.press !== bif.BTN_PRESS ||
                        e.rel !== bif.BTN_REL || e.rpt !== bif.BTN_RPT || e.step !== bif.BTN_STEP) begin
                        n_fail++;
                        $display("FAIL event: got cyc=%0d lvl=%b press=%b rel=%b rpt=%b step=%b, required cyc=%0d lvl=%b press=%b rel=%b rpt=%b step=%b",
                                 cyc, bif.BTN_LVL, bif.BTN_PRESS, bif.BTN_REL, bif.BTN_RPT, bif.BTN_STEP,
                                 e.cyc, e.lvl, e.press, e.rel, e.rpt, e.step);
                    end else begin
                        $display("[TB] event ok: cyc=%0d lvl=%b press=%b rel=%b rpt=%b step=%b",
                                 cyc, e.lvl, e.press, e.rel, e.rpt, e.step);
                    end
                end
                prev_lvl = bif.BTN_LVL;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int p;
        n_tests    = 0;
        n_fail     = 0;
        exp_lvl    = '0;
        rst_n      = 1'b0;
        bif.BTN_IN = 5'b11111;

        // Reset with all buttons held, then released: all are new presses.
        repeat (5) tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        r = cyc;
        exp_lvl = 5'b11111;
        push(r + LAT, exp_lvl, 5'b11111, '0, '0, 5'b11111);
        wait_until(r + LAT);
        bif.BTN_IN = '0;
        exp_lvl = '0;
        push(r + 2 * LAT, exp_lvl, '0, 5'b11111, '0, '0);
        drain("reset_release", 40);

        // Bounce: 3 high / 1 low never satisfies the debounce count.
        for (int k = 0; k < 10; k++) begin
            bif.BTN_IN[0] = 1'b1;
            repeat (3) tick();
            bif.BTN_IN[0] = 1'b0;
            tick();
        end
        drain("bounce", 10);
        check_vec("bounce BTN_LVL", bif.BTN_LVL, '0);

        press_hold(0, 20);
        drain("clean_u", 40);

        press_hold(1, 24);
        drain("hold_l", 40);

        // Release accepted exactly on a repeat expiry cycle (REPEAT state).
        press_hold(2, 7);
        drain("race_repeat_r", 40);

        // Release accepted exactly on the first-repeat cycle (DELAY state).
        press_hold(3, 4);
        drain("race_delay_d", 40);

        press_hold(3, 44);
        drain("hold_d", 40);

        press_hold(4, 5);
        drain("clean_c", 40);

        // Reset mid-press with the button still held through release of reset.
        tick();
        bif.BTN_IN[4] = 1'b1;
        p = cyc + LAT;
        exp_lvl = 5'b10000;
        push(p, exp_lvl, 5'b10000, '0, '0, 5'b10000);
        wait_until(p + 3);
        rst_n = 1'b0;
        exp_lvl = '0;
        #1;
        check_outputs_zero("midreset");
        repeat (3) tick();
        rst_n = 1'b1;
        r = cyc;
        exp_lvl = 5'b10000;
        push(r + LAT, exp_lvl, 5'b10000, '0, '0, 5'b10000);
        wait_until(r + LAT);
        bif.BTN_IN = '0;
        exp_lvl = '0;
        push(r + 2 * LAT, exp_lvl, '0, 5'b10000, '0, '0);
        drain("midreset_release", 40);

        check_vec("final BTN_LVL", bif.BTN_LVL, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
